aes128_iter_core: RTL

//  AES-128 encryption engine (FIPS-197) with a parametrised number of unrolled rounds per clock.

---
 rtl/aes128_iter_core.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/aes128_iter_core.sv
// aes128_iter_core
//   AES-128 encryption engine that applies ROUNDS_PER_CYCLE rounds per clock.
//   One block is encrypted in N = 10/ROUNDS_PER_CYCLE clocks. Round keys are
//   expanded on the fly, alongside the rounds that use them.
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   IN_VALID/READY   input handshake; IN_READY is the only combinational output
//   IN_DATA, IN_KEY  plaintext and key, byte 0 in bits [127:120]
//   OUT_VALID/READY  output handshake
//   OUT_DATA         registered ciphertext, held stable until it is taken
//   BUSY             high while rounds are being applied
module aes128_iter_core #(
  parameter int unsigned ROUNDS_PER_CYCLE = 1,
  parameter int unsigned CNT_W            = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [127:0] IN_DATA,
  input  logic [127:0] IN_KEY,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [127:0] OUT_DATA,
  output logic         BUSY
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
    $error("aes128_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end
  if (CNT_W < 4) begin : g_bad_cnt_w
    $error("aes128_iter_core: CNT_W must be at least 4");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon_of(input logic [CNT_W-1:0] r);
    case (r)
      CNT_W'(1):  return 8'h01;
      CNT_W'(2):  return 8'h02;
      CNT_W'(3):  return 8'h04;
      CNT_W'(4):  return 8'h08;
      CNT_W'(5):  return 8'h10;
      CNT_W'(6):  return 8'h20;
      CNT_W'(7):  return 8'h40;
      CNT_W'(8):  return 8'h80;
      CNT_W'(9):  return 8'h1b;
      CNT_W'(10): return 8'h36;
      default:    return 8'h00;
    endcase
  endfunction

  // Round key r from round key r-1.
  function automatic logic [127:0] next_round_key(input logic [127:0] k,
                                                  input logic [7:0]   rcon);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sub_byte(k[23:16]), sub_byte(k[15:8]), sub_byte(k[7:0]), sub_byte(k[31:24])};
    t  = t ^ {rcon, 24'h000000};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s,
                                             input logic [127:0] rk,
                                             input logic         last);
    logic [0:15][7:0] sb, sr, mc;
    logic [7:0]       a0, a1, a2, a3;
    sb = s;
    for (int unsigned i = 0; i < 16; i++) sb[i] = sub_byte(sb[i]);
    // Byte 4c+r sits in column c, row r; row r rotates left by r columns.
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];
    mc = sr;
    if (!last) begin
      for (int unsigned c = 0; c < 4; c++) begin
        a0 = sr[4*c];
        a1 = sr[4*c+1];
        a2 = sr[4*c+2];
        a3 = sr[4*c+3];
        mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    return mc ^ rk;
  endfunction

  logic [1:0]       fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [127:0]     st_q, st_d;
  logic [127:0]     key_q, key_d;
  logic [127:0]     out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [127:0]     st_chain, key_chain;
  logic [CNT_W-1:0] rnd;
  logic             in_ready;

  // Unrolled round chain: rounds cnt_q .. cnt_q+ROUNDS_PER_CYCLE-1.
  always_comb begin
    st_chain  = st_q;
    key_chain = key_q;
    rnd       = '0;
    for (int unsigned i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      rnd       = cnt_q + CNT_W'(i);
      key_chain = next_round_key(key_chain, rcon_of(rnd));
      st_chain  = aes_round(st_chain, key_chain, rnd == CNT_W'(10));
    end
  end

  always_comb begin
    fsm_d    = fsm_q;
    cnt_d    = cnt_q;
    st_d     = st_q;
    key_d    = key_q;
    out_d    = out_q;
    in_ready = 1'b0;
    case (fsm_q)
      S_IDLE: in_ready = 1'b1;
      S_RUN: begin
        st_d  = st_chain;
        key_d = key_chain;
        cnt_d = cnt_q + CNT_W'(ROUNDS_PER_CYCLE);
        if (cnt_q == CNT_W'(11 - ROUNDS_PER_CYCLE)) begin
          out_d = st_chain;
          cnt_d = '0;
          fsm_d = S_DONE;
        end
      end
      S_DONE: begin
        in_ready = OUT_READY;
        if (OUT_READY) fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
    // A load overrides the DONE->IDLE step so back-to-back blocks have no bubble.
    if (in_ready && IN_VALID) begin
      st_d  = IN_DATA ^ IN_KEY;
      key_d = IN_KEY;
      cnt_d = CNT_W'(1);
      fsm_d = S_RUN;
    end
    out_valid_d = (fsm_d == S_DONE);
    busy_d      = (fsm_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= S_IDLE;
      cnt_q       <= '0;
      st_q        <= '0;
      key_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      st_q        <= st_d;
      key_q       <= key_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign IN_READY  = in_ready;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_q;
  assign BUSY      = busy_q;

endmodule
